demux4_dispatcher: RTL and testbench

Sequencing controller for the 4:1 demultiplexer datapath. Accepts a single valid/ready input stream and delivers each word to exactly one of four output channels. The destination comes from the input's address field (addressed mode) or from an internal round-robin pointer (RR mode). Each word is held in one register until the selected channel accepts it, so the block sits between a single producer and four consumers.

---
 rtl/demux4_dispatcher.sv | 99 +++++++++
 tb/tb_demux4_dispatcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/demux4_dispatcher.sv
// Single-entry dispatcher: one valid/ready producer to four consumers, addressed or round-robin.
// Latency: a word accepted at edge N is offered from cycle N+1; back-to-back 1 word/cycle.
// Backpressure: in_ready follows out_ready[dest]; optional DISPATCH_TIMEOUT_EN drops stalled words.
module demux4_dispatcher #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  input  logic              rr_mode,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              drop
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [7:0] TO_W = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        dest_q;
  logic [1:0]        rr_ptr_q;
  logic              sel_ready;
  logic              accept;
  logic              handoff;
  logic              expire;

  assign sel_ready = out_ready[dest_q];
  assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & sel_ready);
  assign accept    = in_valid & in_ready;
  assign handoff   = (state_q == HOLD) & sel_ready;

`ifdef DISPATCH_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       drop_q;

  // Fires on the stall edge that would bring the counter up to TIMEOUT.
  assign expire = (state_q == HOLD) & ~sel_ready & (wait_cnt_q == TO_W - 8'd1);
  assign drop   = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= expire & ~accept;
      if (accept)
        wait_cnt_q <= 8'd0;
      else if ((state_q == HOLD) & ~sel_ready)
        wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = TO_W;
  assign expire         = 1'b0;
  assign drop           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = HOLD;
    else if (handoff | expire)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      dest_q   <= 2'd0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in_data;
        if (rr_mode) begin
          dest_q   <= rr_ptr_q;
          rr_ptr_q <= rr_ptr_q + 2'd1;
        end else begin
          dest_q <= in_dest;
        end
      end
    end
  end

  assign out_valid = (state_q == HOLD) ? (4'b0001 << dest_q) : 4'b0000;
  assign out_data  = data_q;
  assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Directed bench for demux4_dispatcher with a transaction-level reference model.
module tb_demux4_dispatcher;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_dest;
  logic          rr_mode;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          drop;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  demux4_dispatcher #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: at most one word in flight, pointer kept as an integer mod 4.
  int         m_held = 0;
  logic [7:0] m_data = 8'h00;
  int         m_dest = 0;
  int         m_rr   = 0;
  int         m_wait = 0;
  bit         m_drop = 0;

  always @(posedge clk) begin
    bit rdy, acc, hand, to;
    if (rst) begin
      m_held = 0; m_data = 8'h00; m_dest = 0; m_rr = 0; m_wait = 0; m_drop = 0;
    end else begin
      rdy  = (m_held == 0) || out_ready[m_dest];
      acc  = in_valid && rdy;
      hand = (m_held == 1) && out_ready[m_dest];
      to   = 0;
`ifdef DISPATCH_TIMEOUT_EN
      if (m_held == 1 && !hand) begin
        m_wait++;
        if (m_wait == TO) to = 1;
      end
`endif
      m_drop = to && !acc;
      if (acc) begin
        m_data = in_data;
        if (rr_mode) begin
          m_dest = m_rr;
          m_rr   = (m_rr + 1) % 4;
        end else begin
          m_dest = int'(in_dest);
        end
        m_held = 1;
        m_wait = 0;
      end else if (hand || to) begin
        m_held = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("m_out_valid", {28'd0, out_valid}, (m_held == 1) ? (32'd1 << m_dest) : 32'd0);
      check("m_out_data", {24'd0, out_data}, {24'd0, m_data});
      check("m_busy", {31'd0, busy}, m_held);
      check("m_in_ready", {31'd0, in_ready}, {31'd0, (m_held == 0) || out_ready[m_dest]});
      check("m_drop", {31'd0, drop}, {31'd0, m_drop});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stall;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = 2'd0; rr_mode = 1'b0;
    out_ready = 4'b1111;
    step(); step();
    checking = 1'b1;
    check("rst_out_valid", {28'd0, out_valid}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_out_data", {24'd0, out_data}, 32'h0);
    check("rst_drop", {31'd0, drop}, 32'h0);
    rst = 1'b0;
    step();

    // 1: addressed mode
    in_valid = 1'b1; in_data = 8'hA5; in_dest = 2'd2;
    step();
    check("t1_ov0", {28'd0, out_valid}, 32'b0100);
    check("t1_od0", {24'd0, out_data}, 32'hA5);
    check("t1_rdy", {31'd0, in_ready}, 32'h1);
    in_data = 8'h3C; in_dest = 2'd0;
    step();
    check("t1_ov1", {28'd0, out_valid}, 32'b0001);
    check("t1_od1", {24'd0, out_data}, 32'h3C);
    in_valid = 1'b0;
    step();
    check("t1_idle_busy", {31'd0, busy}, 32'h0);
    check("t1_idle_ov", {28'd0, out_valid}, 32'h0);

    // 2: round-robin, back-to-back
    rr_mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i);
      step();
      check("t2_ov", {28'd0, out_valid}, 32'd1 << (i % 4));
      check("t2_od", {24'd0, out_data}, 32'h10 + i);
    end
    in_valid = 1'b0;
    step();

    // 3: backpressure on channel 3, other ready bits toggled
    rr_mode = 1'b0; in_valid = 1'b1; in_data = 8'h77; in_dest = 2'd3; out_ready = 4'b0111;
    step();
    in_valid = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    stall = 3;
`else
    stall = 5;
`endif
    for (int c = 0; c < stall; c++) begin
      check("t3_ov", {28'd0, out_valid}, 32'b1000);
      check("t3_od", {24'd0, out_data}, 32'h77);
      check("t3_rdy", {31'd0, in_ready}, 32'h0);
      out_ready[0] = ~out_ready[0];
      step();
    end
    out_ready = 4'b1111;
    #1;
    check("t3_rdy_release", {31'd0, in_ready}, 32'h1);
    step();
    check("t3_done", {28'd0, out_valid}, 32'h0);

    // 4: reset while holding 5A for channel 1
    in_valid = 1'b1; in_data = 8'h5A; in_dest = 2'd1; out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    check("t4_ov_hold", {28'd0, out_valid}, 32'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_ov", {28'd0, out_valid}, 32'h0);
    check("t4_busy", {31'd0, busy}, 32'h0);
    check("t4_od", {24'd0, out_data}, 32'h0);
    rr_mode = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 4'b1111;
    step();
    check("t4_rr0", {28'd0, out_valid}, 32'b0001);
    in_valid = 1'b0;
    step();

    // 5: mode change while held (rr_ptr now 1)
    out_ready = 4'b0000; in_valid = 1'b1; in_data = 8'h21;
    step();
    check("t5_ov_rr", {28'd0, out_valid}, 32'b0010);
    rr_mode = 1'b0; in_dest = 2'd3; in_valid = 1'b0;
    step();
    check("t5_ov_kept", {28'd0, out_valid}, 32'b0010);
    out_ready = 4'b1111; in_valid = 1'b1; in_data = 8'h22;
    step();
    check("t5_ov_addr", {28'd0, out_valid}, 32'b1000);
    check("t5_od_addr", {24'd0, out_data}, 32'h22);
    rr_mode = 1'b1; in_data = 8'h23;
    step();
    check("t5_ov_resume", {28'd0, out_valid}, 32'b0100);
    in_valid = 1'b0;
    step();

    // 6: stall with no consumer ready
    rr_mode = 1'b0; in_valid = 1'b1; in_data = 8'h66; in_dest = 2'd1; out_ready = 4'b0000;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t6_ov_stall", {28'd0, out_valid}, 32'b0010);
      check("t6_drop_stall", {31'd0, drop}, 32'h0);
      step();
    end
`ifdef DISPATCH_TIMEOUT_EN
    check("t6_ov_dropped", {28'd0, out_valid}, 32'h0);
    check("t6_drop_pulse", {31'd0, drop}, 32'h1);
    check("t6_busy", {31'd0, busy}, 32'h0);
    step();
    check("t6_drop_end", {31'd0, drop}, 32'h0);
`else
    check("t6_ov_held", {28'd0, out_valid}, 32'b0010);
    check("t6_drop_none", {31'd0, drop}, 32'h0);
    step();
    check("t6_drop_none2", {31'd0, drop}, 32'h0);
    out_ready = 4'b1111;
    step();
    check("t6_released", {28'd0, out_valid}, 32'h0);
`endif
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
